// File: rtl/parity_latency_checker.sv
// Parity and request/response latency checker.
//
// Watches a qualified data bus for parity violations and a req/rsp handshake for
// latency violations. Open transactions are kept in an in-order tracker of age
// counters. Every error is reported as a one-cycle pulse, counted in a saturating
// counter and folded into a sticky flag.
//
// Ports:
//   clk         - sole clock, rising edge
//   rst_        - synchronous active-high reset
//   en          - checker enable; low freezes parity sampling and the tracker
//   clr         - synchronous clear of counters and sticky flag
//   valid       - data/parity qualifier
//   data        - monitored data word
//   parity      - parity bit accompanying data
//   req         - request level; a rising edge opens a transaction
//   rsp         - response strobe; each high cycle closes the oldest transaction
//   par_err     - one-cycle pulse on parity violation
//   lat_err     - one-cycle pulse on bad delay, timeout or spurious rsp
//   ovf_err     - one-cycle pulse when a request is dropped (tracker full)
//   par_cnt     - saturating parity error count
//   lat_cnt     - saturating latency + overflow error count
//   outstanding - number of tracked transactions
//   sticky_err  - set by any error pulse, held until clr or reset
module parity_latency_checker #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ODD     = 0,
   parameter int unsigned MIN_DLY = 1,
   parameter int unsigned MAX_DLY = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                           clk,
   input  logic                           rst_,
   input  logic                           en,
   input  logic                           clr,
   input  logic                           valid,
   input  logic [WIDTH-1:0]               data,
   input  logic                           parity,
   input  logic                           req,
   input  logic                           rsp,
   output logic                           par_err,
   output logic                           lat_err,
   output logic                           ovf_err,
   output logic [CNT_W-1:0]               par_cnt,
   output logic [CNT_W-1:0]               lat_cnt,
   output logic [$clog2(DEPTH+1)-1:0]     outstanding,
   output logic                           sticky_err
);

   localparam int unsigned OW = $clog2(DEPTH + 1);
   localparam logic [7:0] MaxAge = 8'(MAX_DLY);
   // Stored age is one less than the delay seen at the current edge.
   localparam logic [7:0] MinAge = 8'(MIN_DLY - 1);
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic OddBit = 1'(ODD);
   localparam logic [OW-1:0] Full = OW'(DEPTH);

   logic [7:0]       ages_q [DEPTH];
   logic [7:0]       ages_d [DEPTH];
   logic [7:0]       age_inc [DEPTH];
   logic [OW-1:0]    cnt_q, cnt_d, cnt_after_pop;
   logic             req_q;
   logic             par_err_q, par_err_d;
   logic             lat_err_q, lat_err_d;
   logic             ovf_err_q, ovf_err_d;
   logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
   logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic             sticky_q, sticky_d;

   logic             nonempty, timeout, rsp_hit, bad_delay, spurious, pop, push_try, push;
   logic [1:0]       lat_inc;
   logic [CNT_W+1:0] lat_sum;

   always_comb begin
      nonempty  = (cnt_q != '0);
      // Timeout wins over a same-edge rsp so the pair counts as one violation.
      timeout   = en && nonempty && (ages_q[0] == MaxAge);
      rsp_hit   = en && rsp && nonempty && !timeout;
      bad_delay = rsp_hit && (ages_q[0] < MinAge);
      spurious  = en && rsp && !nonempty;
      pop       = timeout || rsp_hit;

      cnt_after_pop = cnt_q - OW'(pop);
      push_try      = en && req && !req_q;
      ovf_err_d     = push_try && (cnt_after_pop == Full);
      push          = push_try && !ovf_err_d;
      cnt_d         = cnt_after_pop + OW'(push);

      par_err_d = en && valid && ((^data ^ parity) != OddBit);
      lat_err_d = timeout || bad_delay || spurious;

      // Unused slots are held at zero, so a push lands on an age-0 slot already.
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(cnt_q)) begin
            age_inc[i] = ages_q[i] + 8'(en);
         end else begin
            age_inc[i] = '0;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         ages_d[i] = age_inc[i];
         if (pop) begin
            if (i < DEPTH - 1) begin
               ages_d[i] = age_inc[i + 1];
            end else begin
               ages_d[i] = '0;
            end
         end
      end

      lat_inc = {1'b0, lat_err_d} + {1'b0, ovf_err_d};
      lat_sum = {2'b00, lat_cnt_q} + {{CNT_W{1'b0}}, lat_inc};

      if (clr) begin
         par_cnt_d = '0;
         lat_cnt_d = '0;
         sticky_d  = 1'b0;
      end else begin
         par_cnt_d = (par_err_d && (par_cnt_q != CntMax)) ? par_cnt_q + 1'b1 : par_cnt_q;
         lat_cnt_d = (lat_sum > {2'b00, CntMax}) ? CntMax : lat_sum[CNT_W-1:0];
         sticky_d  = sticky_q || par_err_d || lat_err_d || ovf_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         for (int i = 0; i < DEPTH; i++) begin
            ages_q[i] <= '0;
         end
         cnt_q     <= '0;
         req_q     <= 1'b0;
         par_err_q <= 1'b0;
         lat_err_q <= 1'b0;
         ovf_err_q <= 1'b0;
         par_cnt_q <= '0;
         lat_cnt_q <= '0;
         sticky_q  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ages_q[i] <= ages_d[i];
         end
         cnt_q     <= cnt_d;
         req_q     <= req;
         par_err_q <= par_err_d;
         lat_err_q <= lat_err_d;
         ovf_err_q <= ovf_err_d;
         par_cnt_q <= par_cnt_d;
         lat_cnt_q <= lat_cnt_d;
         sticky_q  <= sticky_d;
      end
   end

   assign par_err     = par_err_q;
   assign lat_err     = lat_err_q;
   assign ovf_err     = ovf_err_q;
   assign par_cnt     = par_cnt_q;
   assign lat_cnt     = lat_cnt_q;
   assign outstanding = cnt_q;
   assign sticky_err  = sticky_q;

endmodule
